// File: rtl/seq_det_multi_pattern_moore.sv
// seq_det_multi_pattern_moore
//   Moore detector that checks NUM_PAT fixed serial bit patterns of PAT_LEN
//   bits in parallel. Overlapping or non-overlapping detection is chosen at
//   run time. All outputs are registered, so there is no combinational path
//   from in to out.
//
//   Optional build macro: SEQ_MATCH_CNT_EN
//     defined   -> per-pattern saturating match counters with synchronous clear
//     undefined -> match_cnt is tied to 0 and cnt_clr is ignored
//
// Ports
//   clk        in   1              clock, rising edge
//   rst        in   1              synchronous active-high reset
//   in         in   1              serial data bit
//   in_vld     in   1              in is sampled only when 1
//   overlap    in   1              1 = overlapping, 0 = non-overlapping detection
//   out        out  NUM_PAT        out[k] = one-cycle pulse when pattern k matched
//   any_match  out  1              OR of out, same timing
//   match_cnt  out  NUM_PAT*CNT_W  per-pattern match counts, slice k = [k*CNT_W +: CNT_W]
//   cnt_clr    in   1              synchronous clear of match_cnt
module seq_det_multi_pattern_moore #(
  parameter int PAT_LEN = 3,
  parameter int NUM_PAT = 2,
  parameter logic [NUM_PAT*PAT_LEN-1:0] PATTERNS = {3'b110, 3'b101},
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in,
  input  logic                     in_vld,
  input  logic                     overlap,
  output logic [NUM_PAT-1:0]       out,
  output logic                     any_match,
  output logic [NUM_PAT*CNT_W-1:0] match_cnt,
  input  logic                     cnt_clr
);

  localparam int FILL_W = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);

  logic [PAT_LEN-1:0] hist_reg;
  logic [FILL_W-1:0]  fill_reg;
  logic [PAT_LEN-1:0] hist_next;
  logic [FILL_W-1:0]  fill_next;
  logic [NUM_PAT-1:0] match;
  logic [NUM_PAT-1:0] out_reg;
  logic               any_reg;

  // Candidate history/fill if the current bit is accepted; fill saturates so
  // it only tells whether a full pattern's worth of bits has been seen.
  always_comb begin
    hist_next = {hist_reg[PAT_LEN-2:0], in};
    fill_next = (fill_reg == FILL_FULL) ? fill_reg : fill_reg + 1'b1;
  end

  // Match vector is only meaningful on valid edges.
  for (genvar gi = 0; gi < NUM_PAT; gi++) begin : g_match
    assign match[gi] = in_vld && (fill_next == FILL_FULL) &&
                       (hist_next == PATTERNS[gi*PAT_LEN +: PAT_LEN]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_reg <= '0;
      fill_reg <= '0;
      out_reg  <= '0;
      any_reg  <= 1'b0;
    end else if (in_vld) begin
      out_reg <= match;
      any_reg <= |match;
      // Non-overlapping: any match flushes history for every pattern.
      if (!overlap && (|match)) begin
        hist_reg <= '0;
        fill_reg <= '0;
      end else begin
        hist_reg <= hist_next;
        fill_reg <= fill_next;
      end
    end else begin
      // Gap: history is held, output pulse ends.
      out_reg <= '0;
      any_reg <= 1'b0;
    end
  end

  assign out       = out_reg;
  assign any_match = any_reg;

`ifdef SEQ_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_reg [NUM_PAT];

  for (genvar gi = 0; gi < NUM_PAT; gi++) begin : g_cnt
    // Clear beats a coincident match; counting stops at all-ones.
    always_ff @(posedge clk) begin
      if (rst || cnt_clr) begin
        cnt_reg[gi] <= '0;
      end else if (match[gi] && (cnt_reg[gi] != {CNT_W{1'b1}})) begin
        cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
      end
    end
    assign match_cnt[gi*CNT_W +: CNT_W] = cnt_reg[gi];
  end
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_seq_det_multi_pattern_moore.sv
module tb_seq_det_multi_pattern_moore;
  localparam int PAT_LEN = 3;
  localparam int NUM_PAT = 2;
  localparam logic [NUM_PAT*PAT_LEN-1:0] PATTERNS = {3'b110, 3'b101};
  localparam int CNT_W = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic din = 1'b0;
  logic in_vld = 1'b0;
  logic overlap = 1'b0;
  logic cnt_clr = 1'b0;
  logic [NUM_PAT-1:0] out;
  logic any_match;
  logic [NUM_PAT*CNT_W-1:0] match_cnt;

  seq_det_multi_pattern_moore #(
    .PAT_LEN(PAT_LEN), .NUM_PAT(NUM_PAT), .PATTERNS(PATTERNS), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .in(din), .in_vld(in_vld), .overlap(overlap),
    .out(out), .any_match(any_match), .match_cnt(match_cnt), .cnt_clr(cnt_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NUM_PAT-1:0]       o;
    logic                     a;
    logic [NUM_PAT*CNT_W-1:0] c;
    int                       id;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int txn = 0;

  // Reference model: list of bits received since the last reset/flush.
  int bits[$];
  int cnt_m[NUM_PAT];
  logic [NUM_PAT*PAT_LEN-1:0] pats_v;

  function automatic logic [NUM_PAT-1:0] model_step(input logic r, input logic b,
                                                    input logic v, input logic ov,
                                                    input logic clr);
    logic [NUM_PAT-1:0] m;
    int val;
    int p;
    m = '0;
    if (r) begin
      bits.delete();
      for (int k = 0; k < NUM_PAT; k++) cnt_m[k] = 0;
      return m;
    end
    if (v) begin
      bits.push_back(int'(b));
      if (bits.size() >= PAT_LEN) begin
        val = 0;
        for (int i = 0; i < PAT_LEN; i++)
          val = val * 2 + bits[bits.size() - PAT_LEN + i];
        for (int k = 0; k < NUM_PAT; k++) begin
          p = int'(pats_v[k*PAT_LEN +: PAT_LEN]);
          if (val == p) m[k] = 1'b1;
        end
      end
      if (!ov && m != '0) bits.delete();
      while (bits.size() > PAT_LEN) void'(bits.pop_front());
    end
`ifdef SEQ_MATCH_CNT_EN
    for (int k = 0; k < NUM_PAT; k++) begin
      if (clr) cnt_m[k] = 0;
      else if (m[k] && cnt_m[k] < (1 << CNT_W) - 1) cnt_m[k] = cnt_m[k] + 1;
    end
`endif
    return m;
  endfunction

  task automatic step(input logic r, input logic b, input logic v,
                      input logic ov, input logic clr);
    exp_t e;
    @(negedge clk);
    rst = r; din = b; in_vld = v; overlap = ov; cnt_clr = clr;
    e.o = model_step(r, b, v, ov, clr);
    e.a = |e.o;
    e.c = '0;
`ifdef SEQ_MATCH_CNT_EN
    for (int k = 0; k < NUM_PAT; k++) e.c[k*CNT_W +: CNT_W] = CNT_W'(cnt_m[k]);
`endif
    e.id = txn;
    txn++;
    exp_q.push_back(e);
  endtask

  task automatic send_bits(input logic ov, input int n, input logic [31:0] pat);
    for (int i = n - 1; i >= 0; i--) step(1'b0, pat[i], 1'b1, ov, 1'b0);
  endtask

  // Monitor: DUT presents a result after every edge; compare one line each.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks += 3;
        if (out !== e.o) begin
          failures++;
          $display("FAIL out txn=%0d got=%b exp=%b", e.id, out, e.o);
        end
        if (any_match !== e.a) begin
          failures++;
          $display("FAIL any_match txn=%0d got=%b exp=%b", e.id, any_match, e.a);
        end
        if (match_cnt !== e.c) begin
          failures++;
          $display("FAIL match_cnt txn=%0d got=%h exp=%h", e.id, match_cnt, e.c);
        end
        if (out !== e.o || any_match !== e.a || match_cnt !== e.c) begin
          // failure line already printed
        end else begin
          $display("txn %0d out=%b any=%b cnt=%h ok", e.id, out, any_match, match_cnt);
        end
      end
    end
  end

  initial begin
    pats_v = PATTERNS;
    for (int k = 0; k < NUM_PAT; k++) cnt_m[k] = 0;

    // Reset state
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // Overlapping 10101
    send_bits(1'b1, 5, 32'b10101);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    // Non-overlapping 10101 then 101
    send_bits(1'b0, 8, 32'b10101101);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    // 1101 overlapping: 110 then 101
    send_bits(1'b1, 4, 32'b1101);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    // Reset mid-pattern
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    send_bits(1'b1, 2, 32'b10);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    send_bits(1'b1, 4, 32'b1101);
    // Gaps do not break a pattern
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    // Counter saturation: five non-overlapped 101 matches
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_bits(1'b0, 15, 32'b101101101101101);
    // Clear coincident with a match
    send_bits(1'b0, 2, 32'b10);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 99) < 2), 1'($urandom()), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 3));
    end

    // Drain: the monitor must consume every expectation within a bounded time.
    repeat (4) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
